// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, steers next-PC from the jump unit's S1:S0 select, and fills IF/ID.
// Optional FETCH_PERF_CNT_EN adds RedirectCount/StallCount performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instruction,
    input  logic        S0,
    input  logic        S1,
    input  logic        IF_flush,
    input  logic [31:0] JumpToAddress,
    input  logic        prediction,
    input  logic [31:0] JRAddress,
    input  logic [31:0] CorrectAddress,
    input  logic        Stall,
    output logic [31:0] PC,
    output logic [31:0] PC1,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PC1,
    output logic        IFID_Prediction,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] RedirectCount,
    output logic [31:0] StallCount,
`endif
    output logic        IFID_Valid
);

    logic [31:0] sel_pc;

    // Word-addressed; wraps silently at 2^32.
    assign PC1 = PC + 32'd1;

    // An unknown select falls to the default arm so the PC holds instead of absorbing X.
    always_comb begin
        sel_pc = PC;
        case ({S1, S0})
            2'b00:   sel_pc = PC1;
            2'b01:   sel_pc = JumpToAddress;
            2'b10:   sel_pc = JRAddress;
            2'b11:   sel_pc = CorrectAddress;
            default: sel_pc = PC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            PC               <= RESET_PC;
            IFID_Instruction <= 32'd0;
            IFID_PC1         <= 32'd0;
            IFID_Prediction  <= 1'b0;
            IFID_Valid       <= 1'b0;
        end else if (IF_flush) begin
            // Redirect wins over Stall: load the recovery target and squash IF/ID.
            PC               <= sel_pc;
            IFID_Instruction <= 32'd0;
            IFID_PC1         <= 32'd0;
            IFID_Prediction  <= 1'b0;
            IFID_Valid       <= 1'b0;
        end else if (!Stall) begin
            PC               <= sel_pc;
            IFID_Instruction <= Instruction;
            IFID_PC1         <= PC1;
            IFID_Prediction  <= prediction;
            IFID_Valid       <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            RedirectCount <= 32'd0;
            StallCount    <= 32'd0;
        end else begin
            if (IF_flush)
                RedirectCount <= RedirectCount + 32'd1;
            if (Stall && !IF_flush)
                StallCount <= StallCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (RESET_PC = 32'h10).
// Counter checks are included when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] Instruction;
    logic        S0;
    logic        S1;
    logic        IF_flush;
    logic [31:0] JumpToAddress;
    logic        prediction;
    logic [31:0] JRAddress;
    logic [31:0] CorrectAddress;
    logic        Stall;
    logic [31:0] PC;
    logic [31:0] PC1;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PC1;
    logic        IFID_Prediction;
    logic        IFID_Valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] RedirectCount;
    logic [31:0] StallCount;
`endif

    int errors = 0;
    int checks = 0;

    fetch_stage #(.RESET_PC(32'h10)) dut (
        .clk              (clk),
        .rst              (rst),
        .Instruction      (Instruction),
        .S0               (S0),
        .S1               (S1),
        .IF_flush         (IF_flush),
        .JumpToAddress    (JumpToAddress),
        .prediction       (prediction),
        .JRAddress        (JRAddress),
        .CorrectAddress   (CorrectAddress),
        .Stall            (Stall),
        .PC               (PC),
        .PC1              (PC1),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PC1         (IFID_PC1),
        .IFID_Prediction  (IFID_Prediction),
`ifdef FETCH_PERF_CNT_EN
        .RedirectCount    (RedirectCount),
        .StallCount       (StallCount),
`endif
        .IFID_Valid       (IFID_Valid)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sel(input logic [1:0] sel);
        S1 = sel[1];
        S0 = sel[0];
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_ins"},   IFID_Instruction, 32'd0);
        check({tag, "_pc1"},   IFID_PC1, 32'd0);
        check({tag, "_pred"},  {31'd0, IFID_Prediction}, 32'd0);
        check({tag, "_valid"}, {31'd0, IFID_Valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; Instruction = 32'd0; S0 = 1'b0; S1 = 1'b0; IF_flush = 1'b0;
        JumpToAddress = 32'd0; prediction = 1'b0; JRAddress = 32'd0;
        CorrectAddress = 32'd0; Stall = 1'b0;

        // Reset
        step();
        check("rst_pc", PC, 32'h10);
        check("rst_pc1", PC1, 32'h11);
        check_bubble("rst");
`ifdef FETCH_PERF_CNT_EN
        check("rst_rcnt", RedirectCount, 32'd0);
        check("rst_scnt", StallCount, 32'd0);
`endif

        // Sequential fetch
        rst = 1'b1; drive_sel(2'b00); Instruction = 32'hA000_0001;
        step();
        check("seq1_pc", PC, 32'h11);
        check("seq1_ifid_pc1", IFID_PC1, 32'h11);
        check("seq1_ins", IFID_Instruction, 32'hA000_0001);
        check("seq1_valid", {31'd0, IFID_Valid}, 32'd1);
        Instruction = 32'hA000_0002;
        step();
        check("seq2_pc", PC, 32'h12);
        check("seq2_ifid_pc1", IFID_PC1, 32'h12);
        check("seq2_ins", IFID_Instruction, 32'hA000_0002);

        // Redirect to PC=5 via mispredict recovery
        IF_flush = 1'b1; drive_sel(2'b11); CorrectAddress = 32'h5;
        step();
        check("rec5_pc", PC, 32'h5);
        check_bubble("rec5");

        // Predicted jump at PC=5 to 0x40
        IF_flush = 1'b0; drive_sel(2'b01); JumpToAddress = 32'h40;
        prediction = 1'b1; Instruction = 32'hB000_0040;
        step();
        check("jmp_pc", PC, 32'h40);
        check("jmp_ifid_pc1", IFID_PC1, 32'h6);
        check("jmp_ins", IFID_Instruction, 32'hB000_0040);
        check("jmp_pred", {31'd0, IFID_Prediction}, 32'd1);
        check("jmp_valid", {31'd0, IFID_Valid}, 32'd1);

        // Three-cycle stall with select 01 held
        Stall = 1'b1; JumpToAddress = 32'h60; prediction = 1'b0;
        Instruction = 32'hC000_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", PC, 32'h40);
            check("stall_ifid_pc1", IFID_PC1, 32'h6);
            check("stall_ins", IFID_Instruction, 32'hB000_0040);
            check("stall_pred", {31'd0, IFID_Prediction}, 32'd1);
        end
`ifdef FETCH_PERF_CNT_EN
        check("stall_scnt", StallCount, 32'd3);
        check("stall_rcnt", RedirectCount, 32'd1);
`endif
        Stall = 1'b0; prediction = 1'b1;
        step();
        check("unstall_pc", PC, 32'h60);
        check("unstall_ifid_pc1", IFID_PC1, 32'h41);
        check("unstall_ins", IFID_Instruction, 32'hC000_0000);

        // Redirect with simultaneous stall: redirect wins
        IF_flush = 1'b1; Stall = 1'b1; drive_sel(2'b11); CorrectAddress = 32'h22;
        step();
        check("flstall_pc", PC, 32'h22);
        check_bubble("flstall");
`ifdef FETCH_PERF_CNT_EN
        check("flstall_rcnt", RedirectCount, 32'd2);
        check("flstall_scnt", StallCount, 32'd3);
`endif

        // PC wrap at 2^32
        Stall = 1'b0; CorrectAddress = 32'hFFFF_FFFF; prediction = 1'b0;
        step();
        check("wrap_pc", PC, 32'hFFFF_FFFF);
        check("wrap_pc1", PC1, 32'h0);
        IF_flush = 1'b0; drive_sel(2'b00); Instruction = 32'hD000_0000;
        step();
        check("wrap_next_pc", PC, 32'h0);
        check("wrap_ifid_pc1", IFID_PC1, 32'h0);
        check("wrap_valid", {31'd0, IFID_Valid}, 32'd1);

        // JR redirect at the edge
        IF_flush = 1'b1; drive_sel(2'b10); JRAddress = 32'h80;
        step();
        check("jr_pc", PC, 32'h80);
        check_bubble("jr");

        // Reset overrides a pending JR redirect
        prediction = 1'b1; rst = 1'b0; JRAddress = 32'h90;
        step();
        check("rstjr_pc", PC, 32'h10);
        check_bubble("rstjr");
`ifdef FETCH_PERF_CNT_EN
        check("rstjr_rcnt", RedirectCount, 32'd0);
        check("rstjr_scnt", StallCount, 32'd0);
`endif

        // First fetch after reset release is at RESET_PC
        rst = 1'b1; IF_flush = 1'b0; drive_sel(2'b00); prediction = 1'b0;
        Instruction = 32'hE000_0010;
        step();
        check("post_pc", PC, 32'h11);
        check("post_ifid_pc1", IFID_PC1, 32'h11);
        check("post_ins", IFID_Instruction, 32'hE000_0010);
        check("post_valid", {31'd0, IFID_Valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipeline: it owns the program counter, selects the next PC from the fetch-side jump/branch predictor's `S1:S0` steering, and registers the fetched instruction into the IF/ID pipeline register. It sits upstream of decode and alongside the jump/prediction logic. It supplies that logic with `PC`, `PC1` and the fetched instruction, and consumes its `S0`, `S1`, `IF_flush`, `JumpToAddress` and `prediction` outputs.

## Interface
- `RESET_PC`, default 32'h0: PC value loaded on reset.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `Instruction`  in  32  instruction word read combinationally from instruction memory at `PC`.
- `S0`, `S1`  in  1 each  next-PC select from the jump unit.
- `IF_flush`  in  1  squash the IF/ID contents.
- `JumpToAddress`  in  32  predicted jump/branch target from the jump unit.
- `prediction`  in  1  predicted-taken flag for the current fetch.
- `JRAddress`  in  32  register target of a JR resolved in EX.
- `CorrectAddress`  in  32  mispredict recovery PC from EX.
- `Stall`  in  1  hold request from the hazard unit.
- `PC`  out  32  current fetch address, to instruction memory and the jump unit.
- `PC1`  out  32  `PC + 1` (word-addressed), combinational.
- `IFID_Instruction`  out  32  registered instruction.
- `IFID_PC1`  out  32  registered `PC1`.
- `IFID_Prediction`  out  1  registered `prediction`.
- `IFID_Valid`  out  1  the IF/ID slot holds a real instruction.

## Operation
- PC is word-addressed. `PC1 = PC + 1`, computed modulo 2^32. `32'hFFFFFFFF` wraps to 0 with no flag.
- Next-PC select `{S1,S0}`:
  - 00: `PC1`.
  - 01: `JumpToAddress`.
  - 10: `JRAddress`.
  - 11: `CorrectAddress`.
- Redirect: a cycle with `IF_flush`=1 is a redirect. Only selects 10 and 11 occur with `IF_flush`=1.
- Priority, highest first: reset, redirect, `Stall`, normal advance.
- Reset (`rst`=0 at an edge):
  - `PC`←`RESET_PC`.
  - `IFID_Instruction`←0 (NOP).
  - `IFID_PC1`←0, `IFID_Prediction`←0, `IFID_Valid`←0.
- Redirect (`IF_flush`=1):
  - `PC`←selected address, regardless of `Stall`.
  - IF/ID←bubble: instruction 0, `IFID_PC1` 0, `IFID_Prediction` 0, `IFID_Valid` 0.
- Stall (`Stall`=1, no redirect):
  - `PC` and all IF/ID registers hold.
  - A select of 01 is ignored for this cycle. It re-evaluates next cycle from the same held instruction.
- Normal advance:
  - `PC`←select result (00 or 01).
  - IF/ID←{`Instruction`, `PC1`, `prediction`, 1}.
- `IFID_Prediction` travels with its instruction so EX can form `Hit`. It must be 0 for every non-branch instruction, which follows from the input contract.
- No X propagation: if a select input is X, `PC` holds its previous value.

## Timing
- `PC` and the IF/ID registers are the only state, plus the optional counters.
- Predicted jump or backward branch fetched in cycle N:
  - `PC` = target in cycle N+1.
  - The jump/branch itself is in IF/ID in cycle N+1.
  - Zero bubbles.
- Mispredict or JR signalled from EX in cycle N:
  - `PC` = recovery address in N+1.
  - IF/ID is a bubble in N+1.
  - The first correct-path instruction reaches IF/ID in N+2.
- Stall lasting k cycles freezes `PC` and IF/ID for exactly k edges.
- Reset mid-operation overrides pending redirect and stall in the same edge. The first fetch after `rst` returns high is at `RESET_PC`.

## Configuration
- `FETCH_PERF_CNT_EN`, when defined:
  - Adds output ports `RedirectCount` [31:0] and `StallCount` [31:0].
  - `RedirectCount` increments on each edge with `IF_flush`=1.
  - `StallCount` increments on each edge with `Stall`=1 and `IF_flush`=0.
  - Both clear to 0 on reset and wrap modulo 2^32.
- When undefined: the ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- Reset with `RESET_PC`=32'h10, release `rst`, sequential fetch with select 00 → `PC` reads 10, 11, 12. `IFID_PC1` lags one cycle (11, 12). `IFID_Valid` rises on the first edge after release.
- At `PC`=5, `{S1,S0}`=01 with `JumpToAddress`=32'h40 → next `PC`=40. IF/ID holds the jump with `IFID_PC1`=6.
- `Stall`=1 for 3 cycles with select 01 asserted → `PC` is unchanged for 3 cycles, then advances to `JumpToAddress`. `StallCount`=3 when `FETCH_PERF_CNT_EN` is defined.
- `IF_flush`=1 with select 11, `CorrectAddress`=32'h22, and `Stall`=1 in the same cycle → `PC`=22. IF/ID is a bubble (instruction 0, valid 0). `RedirectCount` increments by 1.
- `PC`=32'hFFFFFFFF, select 00 → `PC1`=0 and next `PC`=0.
- Assert `rst`=0 during a JR redirect (select 10, `JRAddress`=32'h80) → `PC`=`RESET_PC`, all IF/ID outputs 0, counters 0.
